// File: rtl/pico_pkg.sv
// Shared encodings for the pico controller: opcodes, ALU function codes,
// instruction field positions and controller states.
package pico_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_ADDI = 4'd2,
    OP_SUB  = 4'd3,
    OP_SUBI = 4'd4,
    OP_MUL  = 4'd5,
    OP_MOV  = 4'd6,
    OP_BEQ  = 4'd7,
    OP_BNE  = 4'd8,
    OP_JMP  = 4'd9,
    OP_INSW = 4'd10,
    OP_OUT  = 4'd11,
    OP_HALT = 4'd15
  } opcode_e;

  typedef enum logic [2:0] {
    RA    = 3'd0,
    RADD  = 3'd1,
    RADDI = 3'd2,
    RSUB  = 3'd3,
    RSUBI = 3'd4,
    RMUL  = 3'd5
  } alu_func_e;

  localparam int unsigned OP_MSB  = 19;
  localparam int unsigned OP_LSB  = 16;
  localparam int unsigned RD_MSB  = 15;
  localparam int unsigned RD_LSB  = 13;
  localparam int unsigned RS_MSB  = 12;
  localparam int unsigned RS_LSB  = 10;
  localparam int unsigned IMM_MSB = 7;
  localparam int unsigned IMM_LSB = 0;

  typedef enum logic [1:0] {
    S_RUN,
    S_WAIT_PRESS,
    S_WAIT_RELEASE,
    S_HALTED
  } state_e;

endpackage

// File: rtl/pico_sync2.sv
// Two-flop synchroniser for an asynchronous level input.
module sync2 (
  input  logic clk,
  input  logic n_reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pico_ctrl.sv
// Pico processor control unit: instruction decode, program counter, Z flag
// and the INSW switch handshake.
module pico_ctrl
  import pico_pkg::*;
#(
  parameter int N  = 8,
  parameter int IW = 20
) (
  input  logic          clk,
  input  logic          n_reset,
  input  logic [IW-1:0] instr,
  input  logic          alu_flag,
  input  logic          sw_go,
  output logic [N-1:0]  pc,
  output logic [2:0]    alu_func,
  output logic [2:0]    rd_addr,
  output logic [2:0]    rs_addr,
  output logic [N-1:0]  imm,
  output logic          reg_we,
  output logic          in_sel,
  output logic          out_we,
  output logic          halted
);

  state_e        state_q, state_d;
  logic [N-1:0]  pc_q, pc_d;
  logic          flag_q, flag_d;
  logic          go_s;
  opcode_e       op;
  logic [N-1:0]  imm_w;
  logic [N-1:0]  pc_inc;
  logic          unused_instr;

  sync2 u_sync (
    .clk     (clk),
    .n_reset (n_reset),
    .d       (sw_go),
    .q       (go_s)
  );

  assign op           = opcode_e'(instr[OP_MSB:OP_LSB]);
  assign imm_w        = (N)'(instr[IMM_MSB:IMM_LSB]);
  assign pc_inc       = pc_q + {{(N-1){1'b0}}, 1'b1};
  assign unused_instr = ^instr;

  assign pc      = pc_q;
  assign imm     = imm_w;
  assign rd_addr = instr[RD_MSB:RD_LSB];
  assign rs_addr = instr[RS_MSB:RS_LSB];
  assign halted  = (state_q == S_HALTED);

  always_comb begin
    case (op)
      OP_ADD:  alu_func = RADD;
      OP_ADDI: alu_func = RADDI;
      OP_SUB:  alu_func = RSUB;
      OP_SUBI: alu_func = RSUBI;
      OP_MUL:  alu_func = RMUL;
      default: alu_func = RA;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flag_d  = flag_q;
    reg_we  = 1'b0;
    in_sel  = 1'b0;
    out_we  = 1'b0;
    case (state_q)
      S_RUN: begin
        case (op)
          OP_ADD, OP_ADDI, OP_SUB, OP_SUBI, OP_MUL: begin
            reg_we = 1'b1;
            flag_d = alu_flag;
            pc_d   = pc_inc;
          end
          OP_MOV: begin
            reg_we = 1'b1;
            pc_d   = pc_inc;
          end
          OP_BEQ:  pc_d = flag_q ? imm_w : pc_inc;
          OP_BNE:  pc_d = flag_q ? pc_inc : imm_w;
          OP_JMP:  pc_d = imm_w;
          OP_INSW: state_d = S_WAIT_PRESS;
          OP_OUT: begin
            out_we = 1'b1;
            pc_d   = pc_inc;
          end
          OP_HALT: state_d = S_HALTED;
          default: pc_d = pc_inc;
        endcase
      end
      // The switch value is written once on the press; pc only advances
      // after release so a held switch cannot feed several INSWs.
      S_WAIT_PRESS: begin
        if (go_s) begin
          reg_we  = 1'b1;
          in_sel  = 1'b1;
          state_d = S_WAIT_RELEASE;
        end
      end
      S_WAIT_RELEASE: begin
        if (!go_s) begin
          pc_d    = pc_inc;
          state_d = S_RUN;
        end
      end
      default: state_d = S_HALTED;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= S_RUN;
      pc_q    <= '0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flag_q  <= flag_d;
    end
  end

endmodule

// File: tb/tb_pico_ctrl.sv
// Scoreboard bench for pico_ctrl: a behavioural model predicts each cycle's
// outputs at stimulus time; a negedge monitor pops and compares.
module tb_pico_ctrl;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic [19:0] instr = '0;
  logic        alu_flag = 1'b0;
  logic        sw_go = 1'b0;
  logic [7:0]  pc;
  logic [2:0]  alu_func;
  logic [2:0]  rd_addr;
  logic [2:0]  rs_addr;
  logic [7:0]  imm;
  logic        reg_we;
  logic        in_sel;
  logic        out_we;
  logic        halted;

  pico_ctrl #(.N(8), .IW(20)) dut (
    .clk      (clk),
    .n_reset  (n_reset),
    .instr    (instr),
    .alu_flag (alu_flag),
    .sw_go    (sw_go),
    .pc       (pc),
    .alu_func (alu_func),
    .rd_addr  (rd_addr),
    .rs_addr  (rs_addr),
    .imm      (imm),
    .reg_we   (reg_we),
    .in_sel   (in_sel),
    .out_we   (out_we),
    .halted   (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  pc;
    logic [3:0]  ctl;   // {reg_we, in_sel, out_we, halted}
    logic [16:0] dec;   // {alu_func, rd, rs, imm}
  } exp_t;

  exp_t sb[$];
  int   n_pass   = 0;
  int   n_checks = 0;

  // Reference model state
  int   m_pc;
  bit   m_flag, m_wait_press, m_wait_release, m_halted;
  bit   h1, h2;   // sw_go driven one and two cycles ago
  logic [19:0] rom [256];

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
  endfunction

  function automatic logic [19:0] mk(int op, int rd, int rs, int im);
    logic [19:0] w;
    w = '0;
    w[19:16] = 4'(op);
    w[15:13] = 3'(rd);
    w[12:10] = 3'(rs);
    w[7:0]   = 8'(im);
    return w;
  endfunction

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("pc", 32'(pc), 32'(e.pc));
      check("ctl{we,in_sel,out_we,halted}", 32'({reg_we, in_sel, out_we, halted}), 32'(e.ctl));
      check("dec{func,rd,rs,imm}", 32'({alu_func, rd_addr, rs_addr, imm}), 32'(e.dec));
    end
  end

  task automatic model_reset();
    m_pc = 0; m_flag = 0; m_wait_press = 0; m_wait_release = 0; m_halted = 0;
    h1 = 0; h2 = 0;
  endtask

  // Called at posedge+1; leaves at the next posedge+1.
  task automatic step(input logic [19:0] ins, input bit flg, input bit go);
    exp_t e;
    int   op, nxt, target;
    bit   gs;
    instr = ins; alu_flag = flg; sw_go = go;
    op     = int'(ins[19:16]);
    target = int'(ins[7:0]);
    gs     = h2;
    nxt    = (m_pc + 1) % 256;
    e.pc   = 8'(m_pc);
    e.ctl  = 4'b0000;
    e.dec  = {((op >= 1 && op <= 5) ? 3'(op) : 3'd0), ins[15:13], ins[12:10], ins[7:0]};
    if (m_halted) begin
      e.ctl = 4'b0001;
    end else if (m_wait_press) begin
      if (gs) begin
        e.ctl = 4'b1100;
        m_wait_press = 0;
        m_wait_release = 1;
      end
    end else if (m_wait_release) begin
      if (!gs) begin
        m_wait_release = 0;
        m_pc = nxt;
      end
    end else begin
      case (op)
        1, 2, 3, 4, 5: begin e.ctl = 4'b1000; m_flag = flg; m_pc = nxt; end
        6:  begin e.ctl = 4'b1000; m_pc = nxt; end
        7:  m_pc = m_flag ? target : nxt;
        8:  m_pc = m_flag ? nxt : target;
        9:  m_pc = target;
        10: m_wait_press = 1;
        11: begin e.ctl = 4'b0010; m_pc = nxt; end
        15: m_halted = 1;
        default: m_pc = nxt;
      endcase
    end
    h2 = h1;
    h1 = go;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    n_reset  = 1'b0;
    instr    = mk(0, 0, 0, 0);
    sw_go    = 1'b0;
    alu_flag = 1'b0;
    #1;
    check("reset_pc_async", 32'(pc), 32'd0);
    check("reset_halted", 32'(halted), 32'd0);
    check("reset_we", 32'({reg_we, in_sel, out_we}), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    n_reset = 1'b1;
    model_reset();
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete, got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit go;
    model_reset();
    do_reset();

    // ADDI r1,#5 then pc advance
    step(mk(2, 1, 0, 5), 0, 0);
    step(mk(0, 0, 0, 0), 0, 0);
    // SUB sets Z, BEQ taken; SUB clears Z, BEQ not taken; BNE taken
    step(mk(3, 1, 2, 0), 1, 0);
    step(mk(7, 0, 0, 8'h40), 0, 0);
    step(mk(3, 1, 2, 0), 0, 0);
    step(mk(7, 0, 0, 8'h40), 1, 0);
    step(mk(8, 0, 0, 8'h20), 1, 0);
    // opcode 13 must not disturb the flag: BEQ still taken afterwards
    step(mk(3, 1, 2, 0), 1, 0);
    step(mk(13, 3, 4, 8'h99), 0, 0);
    step(mk(6, 2, 3, 0), 0, 0);
    step(mk(7, 0, 0, 8'h40), 0, 0);

    // INSW r2 at pc=3 with switch handshake
    do_reset();
    repeat (3) step(mk(0, 0, 0, 0), 0, 0);
    repeat (10) step(mk(10, 2, 0, 0), 0, 0);
    repeat (4) step(mk(10, 2, 0, 0), 0, 1);
    repeat (4) step(mk(10, 2, 0, 0), 0, 0);
    step(mk(0, 0, 0, 0), 0, 0);

    // pc wrap and branch from 255
    step(mk(9, 0, 0, 8'hFF), 0, 0);
    step(mk(0, 0, 0, 0), 0, 0);
    step(mk(9, 0, 0, 8'hFF), 0, 0);
    step(mk(9, 0, 0, 8'h10), 0, 0);
    step(mk(11, 0, 5, 8'h33), 0, 0);

    // HALT freeze, then asynchronous reset
    step(mk(9, 0, 0, 8'h30), 0, 0);
    repeat (20) step(mk(15, 0, 0, 0), 1, 1);
    do_reset();
    step(mk(0, 0, 0, 0), 0, 0);

    // reset while waiting for the switch leaves nothing pending
    step(mk(10, 4, 0, 0), 0, 1);
    step(mk(10, 4, 0, 0), 0, 1);
    step(mk(10, 4, 0, 0), 0, 1);
    do_reset();
    step(mk(0, 0, 0, 0), 0, 0);
    step(mk(0, 0, 0, 0), 0, 0);

    // Random programs
    for (int seg = 0; seg < 4; seg++) begin
      for (int a = 0; a < 256; a++) begin
        logic [19:0] w;
        w = 20'($urandom);
        while (w[19:16] == 4'd15 && $urandom_range(0, 15) != 0)
          w[19:16] = 4'($urandom_range(0, 15));
        rom[a] = w;
      end
      do_reset();
      go = 0;
      for (int s = 0; s < 200; s++) begin
        if ($urandom_range(0, 3) == 0) go = ~go;
        step(rom[m_pc[7:0]], 1'($urandom_range(0, 1)), go);
      end
    end

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
